// File: rtl/exchange_sequencer.sv
// Iteration scheduler for the replica_d exchange array: drives the exponent unit,
// the two-cycle opt_run burst and the exchange shift-out, alternating OR1/TWO pairing.
package exchange_sequencer_pkg;
    typedef enum logic [1:0] {COM_NOP = 2'd0, COM_OR1 = 2'd1, COM_TWO = 2'd2} com_t;
    typedef struct packed {
        com_t       com;
        logic [2:0] rsvd;
    } opt_t;
endpackage

module exchange_sequencer
    import exchange_sequencer_pkg::*;
#(
    parameter int EXP_CYCLES   = 17,
    parameter int REPLICA_NUM  = 32,
    parameter int SHIFT_CYCLES = REPLICA_NUM,
    parameter int ITER_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ITER_W-1:0] iter_num,
    input  logic [16:0]       recip_in,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              opt_run,
    output opt_t              opt,
    output logic              exp_init,
    output logic              exp_run,
    output logic              exp_fin,
    output logic [16:0]       exp_recip,
    output logic              exchange_shift_d
);

    localparam int STEP_MAX = (EXP_CYCLES > SHIFT_CYCLES) ? EXP_CYCLES : SHIFT_CYCLES;
    localparam int STEP_W   = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;
    localparam logic [STEP_W-1:0] EXP_LAST   = STEP_W'(EXP_CYCLES - 1);
    localparam logic [STEP_W-1:0] SHIFT_LAST = STEP_W'(SHIFT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_EXP_INIT, S_EXP_RUN, S_EXP_FIN, S_OPT, S_SHIFT, S_NEXT, S_DONE
    } state_t;

    state_t            state;
    logic [STEP_W-1:0] step;
    logic              parity;
    logic              gap;
    logic [ITER_W-1:0] iter_num_q;
    logic [ITER_W-1:0] iter_cnt_inc;

    assign iter_cnt_inc = iter_cnt + ITER_W'(1);

    // Outputs are assigned for the state being entered, so each is a clean register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            step             <= '0;
            parity           <= 1'b0;
            gap              <= 1'b0;
            iter_num_q       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            iter_cnt         <= '0;
            opt_run          <= 1'b0;
            opt              <= '0;
            exp_init         <= 1'b0;
            exp_run          <= 1'b0;
            exp_fin          <= 1'b0;
            exp_recip        <= '0;
            exchange_shift_d <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        iter_cnt <= '0;
                        if (iter_num != '0) begin
                            iter_num_q <= iter_num;
                            exp_recip  <= recip_in;
                            parity     <= 1'b0;
                            busy       <= 1'b1;
                            exp_init   <= 1'b1;
                            state      <= S_EXP_INIT;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_EXP_INIT: begin
                    exp_init <= 1'b0;
                    exp_run  <= 1'b1;
                    step     <= '0;
                    state    <= S_EXP_RUN;
                end
                S_EXP_RUN: begin
                    if (step == EXP_LAST) begin
                        exp_run <= 1'b0;
                        exp_fin <= 1'b1;
                        step    <= '0;
                        state   <= S_EXP_FIN;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                S_EXP_FIN: begin
                    exp_fin  <= 1'b0;
                    opt_run  <= 1'b1;
                    opt.com  <= parity ? COM_TWO : COM_OR1;
                    step     <= '0;
                    state    <= S_OPT;
                end
                S_OPT: begin
                    if (step != '0) begin
                        opt_run <= 1'b0;
                        opt.com <= COM_NOP;
                        gap     <= 1'b1;
                        step    <= '0;
                        state   <= S_SHIFT;
                    end else begin
                        step <= STEP_W'(1);
                    end
                end
                S_SHIFT: begin
                    // First SHIFT cycle is idle so replica exchange_l can fall back to NOP.
                    if (gap) begin
                        gap              <= 1'b0;
                        exchange_shift_d <= 1'b1;
                        step             <= '0;
                    end else if (step == SHIFT_LAST) begin
                        exchange_shift_d <= 1'b0;
                        step             <= '0;
                        state            <= S_NEXT;
                    end else begin
                        step <= step + STEP_W'(1);
                    end
                end
                S_NEXT: begin
                    iter_cnt <= iter_cnt_inc;
                    parity   <= ~parity;
                    if (iter_cnt_inc == iter_num_q || abort) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        exp_init <= 1'b1;
                        state    <= S_EXP_INIT;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
